src_prop_mem_responder: RTL and testbench
=========================================

SRC_PROP_MEM_RESPONDER -- requirements
Module: src_prop_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, property-memory index width; depth is 2**ADDR_W entries.
REQ-002 SHALL have parameter NUM_VERTICES, default 200, count of valid vertex ids.
REQ-003 SHALL have parameter LATENCY, default 3, request-accept to complete delay in cycles; legal range 1..15.
REQ-004 SHALL have parameter OUTSTANDING, default 4, maximum in-flight requests; legal range 1..8.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 req_valid  input  1  read-property request from the ReadSrcProperty stage.
REQ-009 req_vertex_id  input  32  vertex id to read.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 complete  output  1  head response valid; drives the stage's complete input.
REQ-012 src_data  output  64  property value of the head response.
REQ-013 resp_err  output  1  head response addresses an out-of-range vertex.
REQ-014 resp_accept  input  1  stage consumes the head response.
REQ-015 wr_en  input  1  preload write strobe.
REQ-016 wr_addr  input  ADDR_W  preload index.
REQ-017 wr_data  input  64  preload value.

Function
REQ-018 SHALL accept a request on a cycle when req_valid and req_ready are both 1.
REQ-019 SHALL drive req_ready = (in-flight count < OUTSTANDING), from registered state only; a retirement in the same cycle SHALL NOT raise req_ready in that cycle.
REQ-020 SHALL sample memory data at acceptance; if wr_en hits the same index in the same cycle, SHALL return wr_data (write-first).
REQ-021 SHALL track each in-flight entry with a down-counter loaded with LATENCY at acceptance and decremented every cycle down to 0.
REQ-022 SHALL assert complete for a request accepted at cycle N no earlier than cycle N+LATENCY, and exactly at N+LATENCY when the FIFO is not stalled.
REQ-023 SHALL return responses strictly in acceptance order.
REQ-024 SHALL hold complete, src_data and resp_err stable until the cycle in which resp_accept=1 while complete=1; the head retires on that edge.
REQ-025 SHALL ignore resp_accept while complete=0.
REQ-026 SHALL continue to decrement non-head counters while the head is stalled, so that queued entries complete back-to-back after release.
REQ-027 SHALL allow acceptance and retirement in the same cycle; the count is then unchanged.
REQ-028 SHALL maintain states IDLE (count=0), WAIT (count>0, head counter>0) and RESP (head counter=0, complete=1); IDLE->WAIT on accept; WAIT->RESP when the head counter reaches 0; RESP->WAIT or IDLE on retire, depending on the remaining count and the next head counter.
REQ-029 SHALL wrap the FIFO read and write pointers modulo OUTSTANDING.
REQ-030 SHALL apply a preload write when wr_en=1, independent of request traffic.

Reset
REQ-031 On reset SHALL set count, pointers and state to 0/IDLE, and drive complete=0, src_data=0, resp_err=0 and req_ready=0.
REQ-032 SHALL drive req_ready=1 in the first cycle after reset deasserts.
REQ-033 Reset mid-operation SHALL discard all in-flight requests without emitting complete.
REQ-034 SHALL NOT clear property memory contents on reset.

Configuration
REQ-035 With SRC_PROP_OOB_CHECK_EN defined, a request with req_vertex_id >= NUM_VERTICES SHALL complete with the normal latency, src_data=0 and resp_err=1.
REQ-036 Without SRC_PROP_OOB_CHECK_EN, the responder SHALL index memory with req_vertex_id[ADDR_W-1:0] and tie resp_err to 0.

Verification
REQ-037 Preload idx 5 = 0x0000_0000_DEAD_BEEF, then request id 5 at cycle 10 with resp_accept=1 -> complete=1 with that data at cycle 13 only.
REQ-038 Issue 4 back-to-back requests (ids 1..4) with resp_accept=0 -> req_ready=0 after the 4th; raise resp_accept -> 4 in-order completes on consecutive cycles.
REQ-039 At full occupancy, retire and present a new request in the same cycle -> new request not accepted that cycle; accepted the next cycle.
REQ-040 In the same cycle, write idx 7=0x11 and request id 7 -> src_data=0x11.
REQ-041 Assert reset with 3 requests in flight -> no complete afterwards; req_ready=1 the cycle after reset drops.
REQ-042 With SRC_PROP_OOB_CHECK_EN defined, request id 250 -> complete at +3 cycles with src_data=0 and resp_err=1; without the macro, the response returns memory idx 250 and resp_err=0.

Source files
------------

// File: rtl/src_prop_mem_responder.sv
// Source-property memory responder: preloadable 64-bit property RAM answering in-order read requests
// after a fixed latency. Optional macro SRC_PROP_OOB_CHECK_EN flags out-of-range vertex ids.
module src_prop_mem_responder #(
    parameter int ADDR_W       = 8,
    parameter int NUM_VERTICES = 200,
    parameter int LATENCY      = 3,
    parameter int OUTSTANDING  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_vertex_id,
    output logic              req_ready,
    output logic              complete,
    output logic [63:0]       src_data,
    output logic              resp_err,
    input  logic              resp_accept,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [63:0]       wr_data
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int DEPTH = 1 << ADDR_W;
    // The acceptance cycle itself counts toward the latency, so the counter
    // holds the cycles still remaining after the request is registered.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [63:0]      mem       [DEPTH];
    logic [63:0]      fifo_data [OUTSTANDING];
    logic             fifo_err  [OUTSTANDING];
    logic [3:0]       fifo_cnt  [OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [3:0]       count, count_next, head_cnt_next;
    state_t           state, state_next;

    logic              accept, retire, acc_err;
    logic [ADDR_W-1:0] rd_idx;
    logic [63:0]       mem_word, acc_data;
    logic              unused_id_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [3:0] cnt_dec(input logic [3:0] c);
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
    endfunction

    assign req_ready = !reset && (count < 4'(OUTSTANDING));
    assign accept    = req_valid && req_ready;
    assign complete  = (state == RESP);
    assign retire    = complete && resp_accept;
    assign src_data  = complete ? fifo_data[rd_ptr] : '0;
    assign resp_err  = complete && fifo_err[rd_ptr];

    assign rd_idx         = req_vertex_id[ADDR_W-1:0];
    assign mem_word       = (wr_en && wr_addr == rd_idx) ? wr_data : mem[rd_idx];
    assign unused_id_bits = ^req_vertex_id;

`ifdef SRC_PROP_OOB_CHECK_EN
    assign acc_err  = (req_vertex_id >= 32'(NUM_VERTICES));
    assign acc_data = acc_err ? '0 : mem_word;
`else
    assign acc_err  = 1'b0;
    assign acc_data = mem_word;
`endif

    // Next head is whichever entry sits at the post-retire read pointer;
    // it may be the request being written this very cycle.
    always_comb begin
        rd_ptr_next   = retire ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_next   = accept ? ptr_inc(wr_ptr) : wr_ptr;
        count_next    = count + 4'(accept) - 4'(retire);
        head_cnt_next = cnt_dec(fifo_cnt[rd_ptr_next]);
        if (accept && wr_ptr == rd_ptr_next)
            head_cnt_next = CNT_LOAD;

        state_next = state;
        if (count_next == 4'd0)
            state_next = IDLE;
        else if (head_cnt_next == 4'd0)
            state_next = RESP;
        else
            state_next = WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < OUTSTANDING; i++)
                fifo_cnt[i] <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (accept && wr_ptr == PTR_W'(i))
                    fifo_cnt[i] <= CNT_LOAD;
                else
                    fifo_cnt[i] <= cnt_dec(fifo_cnt[i]);
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_data[wr_ptr] <= acc_data;
            fifo_err[wr_ptr]  <= acc_err;
        end
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_src_prop_mem_responder.sv
// Directed self-checking bench for src_prop_mem_responder (default parameters).
module tb_src_prop_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_vertex_id;
    logic        req_ready;
    logic        complete;
    logic [63:0] src_data;
    logic        resp_err;
    logic        resp_accept;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;

    int total = 0;
    int bad   = 0;

    src_prop_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_vertex_id (req_vertex_id),
        .req_ready     (req_ready),
        .complete      (complete),
        .src_data      (src_data),
        .resp_err      (resp_err),
        .resp_accept   (resp_accept),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        total++; if (complete !== 1'b0) begin bad++; $display("FAIL reset_complete: got %b want 0", complete); end
        total++; if (src_data !== 64'd0) begin bad++; $display("FAIL reset_data: got %h want 0", src_data); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", resp_err); end
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_latency();
        preload(8'd5, 64'h0000_0000_DEAD_BEEF);
        resp_accept = 1'b1;
        req_valid = 1'b1; req_vertex_id = 32'd5;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (complete !== 1'(k == 3)) begin bad++; $display("FAIL latency_complete_c%0d: got %b want %b", k, complete, (k == 3)); end
            if (k == 3) begin
                total++;
                if (src_data !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL latency_data: got %h want deadbeef", src_data); end
            end
            tick();
        end
        resp_accept = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) preload(8'(i), 64'h100 + 64'(i));
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_vertex_id = 32'(i);
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready: got %b want 0", req_ready); end
        tick(); tick();
        total++; if (complete !== 1'b1 || src_data !== 64'h101) begin bad++; $display("FAIL b2b_stall_hold: got %b/%h want 1/101", complete, src_data); end
        resp_accept = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (complete !== 1'b1 || src_data !== 64'h100 + 64'(i)) begin bad++; $display("FAIL b2b_order_%0d: got %b/%h want 1/%h", i, complete, src_data, 64'h100 + 64'(i)); end
            tick();
        end
        total++; if (complete !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", complete); end
        resp_accept = 1'b0;
    endtask

    task automatic test_full_same_cycle();
        logic [63:0] exp_seq [4];
        exp_seq[0] = 64'h102; exp_seq[1] = 64'h103; exp_seq[2] = 64'h104; exp_seq[3] = 64'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_vertex_id = 32'(i);
            tick();
        end
        req_valid = 1'b0;
        tick(); tick();
        resp_accept = 1'b1; req_valid = 1'b1; req_vertex_id = 32'd5;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_retire_ready: got %b want 0", req_ready); end
        tick();
        resp_accept = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_next_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_accepted_next: got %b want 0", req_ready); end
        resp_accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (complete !== 1'b1 || src_data !== exp_seq[i]) begin bad++; $display("FAIL full_order_%0d: got %b/%h want 1/%h", i, complete, src_data, exp_seq[i]); end
            tick();
        end
        total++; if (complete !== 1'b0) begin bad++; $display("FAIL full_drained: got %b want 0", complete); end
        resp_accept = 1'b0;
    endtask

    task automatic test_write_first();
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 64'h11;
        req_valid = 1'b1; req_vertex_id = 32'd7;
        resp_accept = 1'b1;
        tick();
        wr_en = 1'b0; req_valid = 1'b0;
        tick(); tick();
        total++; if (complete !== 1'b1 || src_data !== 64'h11) begin bad++; $display("FAIL write_first: got %b/%h want 1/11", complete, src_data); end
        tick();
        resp_accept = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1'b1; req_vertex_id = 32'(i);
            tick();
        end
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
        resp_accept = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (complete !== 1'b0) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_complete: got %b want 0", seen); end
        resp_accept = 1'b0;
    endtask

    task automatic test_mem_retained();
        resp_accept = 1'b1;
        req_valid = 1'b1; req_vertex_id = 32'd1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        total++; if (complete !== 1'b1 || src_data !== 64'h101) begin bad++; $display("FAIL mem_retained: got %b/%h want 1/101", complete, src_data); end
        tick();
        resp_accept = 1'b0;
    endtask

    task automatic test_oob();
        logic [63:0] exp_data;
`ifdef SRC_PROP_OOB_CHECK_EN
        logic        exp_err = 1'b1;
        preload(8'd250, 64'hABCD_0123);
        exp_data = 64'd0;
`else
        logic        exp_err = 1'b0;
        preload(8'd250, 64'hABCD_0123);
        exp_data = 64'hABCD_0123;
`endif
        resp_accept = 1'b1;
        req_valid = 1'b1; req_vertex_id = 32'd250;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (complete !== 1'(k == 3)) begin bad++; $display("FAIL oob_complete_c%0d: got %b want %b", k, complete, (k == 3)); end
            if (k == 3) begin
                total++;
                if (src_data !== exp_data || resp_err !== exp_err) begin bad++; $display("FAIL oob_resp: got %h/%b want %h/%b", src_data, resp_err, exp_data, exp_err); end
            end
            tick();
        end
        resp_accept = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_vertex_id = '0; resp_accept = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_full_same_cycle();
        test_write_first();
        test_reset_midflight();
        test_mem_retained();
        test_oob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
